// File: rtl/uni_deser_rx.sv
// rtl/uni_deser_rx.sv - framed serial-to-parallel receiver with one-entry output register
// Overrun and frame errors are sticky until err_clr.
module uni_deser_rx #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_in,
  input  logic         s_valid,
  input  logic         s_start,
  output logic [N-1:0] p_out,
  output logic         p_valid,
  input  logic         p_ready,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err,
  input  logic         err_clr
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sr, sr_nxt, shifted, start_word;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           complete, restart;

  // LSB-first shifts right inserting at the MSB; MSB-first shifts left inserting at the LSB.
  function automatic logic [N-1:0] insert_bit(input logic [N-1:0] cur, input logic b);
    if (LSB_FIRST) return {b, cur[N-1:1]};
    else           return {cur[N-2:0], b};
  endfunction

  assign shifted    = insert_bit(sr, s_in);
  assign start_word = insert_bit('0, s_in);
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    complete  = 1'b0;
    restart   = 1'b0;
    if (s_valid) begin
      if (s_start) begin
        restart   = (state == SHIFT);
        sr_nxt    = start_word;
        cnt_nxt   = CW'(1);
        state_nxt = SHIFT;
      end else if (state == SHIFT) begin
        sr_nxt = shifted;
        if (cnt == CW'(N - 1)) begin
          complete  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr        <= '0;
      cnt       <= '0;
      p_out     <= '0;
      p_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sr  <= sr_nxt;
      cnt <= cnt_nxt;
      // A completion may refill the register on the same edge the consumer drains it.
      if (complete && (!p_valid || p_ready)) begin
        p_out   <= shifted;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
      overrun   <= (complete && p_valid && !p_ready) || (overrun && !err_clr);
      frame_err <= restart || (frame_err && !err_clr);
    end
  end

endmodule
